hyperbus_native_responder: RTL and testbench

Single-clock responder for the Hyperbus native memory interface. It accepts read and write requests from an initiator, such as the Hyperbus FIFO bridge, and serves them from an internal word-addressed RAM. It applies a programmable initial latency, a fixed burst length and optional wait-state injection. It is used as the native-side memory model in bridge verification, and as a scratch memory behind the native interface in FPGA builds that have no Hyperbus device.

---
 rtl/hyperbus_native_responder.sv | 95 +++++++++
 tb/tb_hyperbus_native_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_native_responder.sv
// Native-side Hyperbus memory model: word-addressed RAM served with a programmable
// initial latency, a fixed burst length and per-cycle wait-state injection.
module hyperbus_native_responder #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int LATENCY         = 6,
  parameter int BURST           = 2
) (
  input  logic                       hbus_clk,
  input  logic                       hbus_rst,
  input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
  input  logic                       hbus_rrq,
  input  logic                       hbus_wrq,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  output logic                       hbus_ready,
  output logic                       hbus_valid,
  output logic                       hbus_busy,
  input  logic                       stall
);
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int CW    = $clog2(BURST + 1);
  localparam int LW    = $clog2(LATENCY + 2);

  typedef enum logic [2:0] {IDLE, LAT, READ, WRITE, DONE} state_t;

  state_t                    state;
  logic [MEM_DEPTH_LOG2-1:0] ptr;
  logic [CW-1:0]             cnt;
  logic [LW-1:0]             lat;
  logic                      dir_rd;
  logic [HBUS_DATA_WIDTH-1:0] mem [DEPTH];

  // Only the low address bits select a word; the rest are don't-care.
  logic unused_adr_bits;
  assign unused_adr_bits = ^hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_DEPTH_LOG2];

  assign hbus_ready = (state == WRITE) && !stall;

  // RAM has no reset so contents survive hbus_rst.
  always_ff @(posedge hbus_clk)
    if (hbus_ready) mem[ptr] <= hbus_dat_i;

  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      lat        <= '0;
      dir_rd     <= 1'b0;
      hbus_dat_o <= '0;
      hbus_valid <= 1'b0;
      hbus_busy  <= 1'b0;
    end else begin
      hbus_valid <= 1'b0;
      case (state)
        IDLE: if (hbus_rrq || hbus_wrq) begin
          ptr       <= hbus_adr_i[MEM_DEPTH_LOG2-1:0];
          cnt       <= CW'(BURST);
          lat       <= LW'(LATENCY);
          dir_rd    <= hbus_rrq;
          hbus_busy <= 1'b1;
          if (LATENCY == 0) state <= hbus_rrq ? READ : WRITE;
          else              state <= LAT;
        end
        LAT: begin
          lat <= lat - 1'b1;
          if (lat == LW'(1)) state <= dir_rd ? READ : WRITE;
        end
        READ: if (!stall) begin
          hbus_dat_o <= mem[ptr];
          hbus_valid <= 1'b1;
          ptr        <= ptr + 1'b1;
          cnt        <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= DONE;
            hbus_busy <= 1'b0;
          end
        end
        WRITE: if (!stall) begin
          ptr <= ptr + 1'b1;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= DONE;
            hbus_busy <= 1'b0;
          end
        end
        // Wait for both levels to drop so a held request is not served twice.
        DONE: if (!hbus_rrq && !hbus_wrq) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hyperbus_native_responder.sv
// Two responders (LATENCY=6/BURST=2/1K words and LATENCY=0/BURST=3/16 words) share stimulus;
// a monitor pops expected beats from per-instance queues filled by the driver's reference model.
module tb_hyperbus_native_responder;
  localparam int LATV[2] = '{6, 0};
  localparam int BSTV[2] = '{2, 3};
  localparam int DEPV[2] = '{1024, 16};

  typedef struct { int cyc; logic [15:0] d; bit kn; } exp_t;

  logic        hbus_clk = 1'b0;
  logic        hbus_rst;
  logic [31:0] adr;
  logic        rrq, wrq, stall;
  logic [15:0] dat_i [2];
  logic [15:0] dout  [2];
  logic        rdy [2], vld [2], bsy [2];

  int   cyc = 0, errors = 0, checks = 0;
  int   p0 = -1000;
  int   bend [2] = '{0, 0};
  bit   mon_en = 1'b0;
  exp_t rq [2][$];
  int   wq [2][$];
  logic [15:0] mm [2][1024];
  bit          kn [2][1024];

  always #5 hbus_clk = ~hbus_clk;
  always @(posedge hbus_clk) cyc <= cyc + 1;

  hyperbus_native_responder #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16), .MEM_DEPTH_LOG2(10),
    .LATENCY(6), .BURST(2)) u_a (
    .hbus_clk(hbus_clk), .hbus_rst(hbus_rst), .hbus_adr_i(adr), .hbus_rrq(rrq), .hbus_wrq(wrq),
    .hbus_dat_i(dat_i[0]), .hbus_dat_o(dout[0]), .hbus_ready(rdy[0]), .hbus_valid(vld[0]),
    .hbus_busy(bsy[0]), .stall(stall));

  hyperbus_native_responder #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16), .MEM_DEPTH_LOG2(4),
    .LATENCY(0), .BURST(3)) u_b (
    .hbus_clk(hbus_clk), .hbus_rst(hbus_rst), .hbus_adr_i(adr), .hbus_rrq(rrq), .hbus_wrq(wrq),
    .hbus_dat_i(dat_i[1]), .hbus_dat_o(dout[1]), .hbus_ready(rdy[1]), .hbus_valid(vld[1]),
    .hbus_busy(bsy[1]), .stall(stall));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endfunction

  task automatic chk_zero(string tag);
    for (int x = 0; x < 2; x++) begin
      chk({tag, "_valid"}, {31'd0, vld[x]}, 0);
      chk({tag, "_ready"}, {31'd0, rdy[x]}, 0);
      chk({tag, "_busy"},  {31'd0, bsy[x]}, 0);
      chk({tag, "_dat"},   {16'd0, dout[x]}, 0);
    end
  endtask

  // Monitor: busy window per cycle, and every valid/ready beat against the queues.
  always @(negedge hbus_clk) if (mon_en) begin
    for (int x = 0; x < 2; x++) begin
      exp_t e;
      int   wc;
      chk(x ? "b_busy" : "a_busy", {31'd0, bsy[x]}, {31'd0, (cyc >= p0 && cyc <= p0 + bend[x] - 1)});
      if (vld[x]) begin
        if (rq[x].size() == 0) chk(x ? "b_extra_valid" : "a_extra_valid", 1, 0);
        else begin
          e = rq[x].pop_front();
          chk(x ? "b_valid_cyc" : "a_valid_cyc", cyc, e.cyc);
          if (e.kn) chk(x ? "b_rdata" : "a_rdata", {16'd0, dout[x]}, {16'd0, e.d});
        end
      end
      if (rdy[x]) begin
        if (wq[x].size() == 0) chk(x ? "b_extra_ready" : "a_extra_ready", 1, 0);
        else begin
          wc = wq[x].pop_front();
          chk(x ? "b_ready_cyc" : "a_ready_cyc", cyc, wc);
        end
      end
    end
  end

  // One transaction on both instances. Cycle n is the clock period after edge E(n-1),
  // E0 being the accepting edge. fst forces a stall in cycle fst; rst_at>0 pulses reset
  // in the middle of cycle rst_at.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input int sp,
                     input int fst, input int hold, input int rst_at,
                     input logic [15:0] w0, input logic [15:0] w1);
    bit          st [64];
    int          dc [2][4];
    int          last [2];
    logic [15:0] wd [3];
    int          nmax, eff, ad, k;
    @(negedge hbus_clk);
    for (int n = 0; n < 64; n++)
      st[n] = (n > 0) && (n < 40) && ((n == fst) || ($urandom_range(99) < sp));
    wd[0] = w0; wd[1] = w1; wd[2] = 16'($urandom());
    // Data phase starts at cycle LATENCY+1; each non-stalled cycle moves one word.
    for (int x = 0; x < 2; x++) begin
      k = 0;
      for (int n = LATV[x] + 1; n < 64 && k < BSTV[x]; n++)
        if (!st[n]) begin dc[x][k] = n; k++; end
      last[x] = dc[x][BSTV[x]-1];
    end
    rrq = rd; wrq = wr; adr = a; stall = 1'b0;
    @(posedge hbus_clk); #1;
    p0  = cyc;
    eff = (rst_at > 0) ? rst_at : 1000;
    for (int x = 0; x < 2; x++) begin
      bend[x] = (last[x] < eff - 1) ? last[x] : eff - 1;
      for (int j = 0; j < BSTV[x]; j++) begin
        ad = (int'(a[9:0]) + j) % DEPV[x];
        if (rd) begin
          if (dc[x][j] + 1 < eff) rq[x].push_back('{p0 + dc[x][j], mm[x][ad], kn[x][ad]});
        end else if (dc[x][j] < eff) begin
          wq[x].push_back(p0 + dc[x][j] - 1);
          mm[x][ad] = wd[j];
          kn[x][ad] = 1'b1;
        end
      end
    end
    nmax = ((last[0] > last[1]) ? last[0] : last[1]) + 1;
    if (hold > nmax) nmax = hold;
    if (rst_at > 0) nmax = rst_at;
    for (int n = 1; n <= nmax; n++) begin
      stall = st[n];
      for (int x = 0; x < 2; x++) begin
        dat_i[x] = 16'($urandom());
        for (int j = 0; j < BSTV[x]; j++) if (!rd && dc[x][j] == n) dat_i[x] = wd[j];
      end
      if (n > hold) begin rrq = 1'b0; wrq = 1'b0; end
      if (n == rst_at) begin
        hbus_rst = 1'b1; rrq = 1'b0; wrq = 1'b0;
        #1 chk_zero("async_rst");
      end
      @(posedge hbus_clk); #1;
    end
    rrq = 1'b0; wrq = 1'b0; stall = 1'b0; hbus_rst = 1'b0;
    @(posedge hbus_clk); #1;
    for (int x = 0; x < 2; x++) begin
      chk(x ? "b_rd_drain" : "a_rd_drain", rq[x].size(), 0);
      chk(x ? "b_wr_drain" : "a_wr_drain", wq[x].size(), 0);
    end
  endtask

  initial begin
    int          lo, mode;
    logic [31:0] r;
    for (int x = 0; x < 2; x++) for (int i = 0; i < 1024; i++) begin mm[x][i] = '0; kn[x][i] = 1'b0; end
    hbus_rst = 1'b1; rrq = 1'b0; wrq = 1'b0; stall = 1'b0; adr = '0;
    dat_i[0] = '0; dat_i[1] = '0;
    repeat (3) @(posedge hbus_clk);
    #1 chk_zero("reset");
    hbus_rst = 1'b0;
    mon_en   = 1'b1;

    txn(0, 1, 32'h10, 0, -1, 1, 0, 16'hAAAA, 16'h5555);         // write 0x10
    txn(1, 0, 32'h10, 0, -1, 1, 0, 16'h0, 16'h0);               // read back
    txn(1, 0, 32'h10, 0, 7, 1, 0, 16'h0, 16'h0);                // stall on first data cycle
    txn(0, 1, 32'h40, 0, -1, 20, 0, 16'h1234, 16'h5678);        // held write
    txn(1, 0, 32'h40, 0, -1, 1, 0, 16'h0, 16'h0);
    txn(0, 1, 32'h3FF, 0, -1, 1, 0, 16'hBEEF, 16'hCAFE);        // wrap-around
    txn(1, 0, 32'h3FF, 0, -1, 1, 0, 16'h0, 16'h0);
    txn(1, 0, 32'hFFFF_0010, 0, -1, 1, 0, 16'h0, 16'h0);        // upper bits ignored
    txn(1, 1, 32'h10, 0, -1, 1, 0, 16'hDEAD, 16'hDEAD);         // read wins
    txn(1, 0, 32'h10, 0, -1, 1, 0, 16'h0, 16'h0);
    txn(0, 1, 32'h20, 0, -1, 1, 0, 16'h1111, 16'h2222);
    txn(0, 1, 32'h20, 0, -1, 1, 8, 16'h3333, 16'h4444);         // reset after first word
    txn(1, 0, 32'h20, 0, -1, 1, 0, 16'h0, 16'h0);

    for (int t = 0; t < 150; t++) begin
      lo   = ($urandom_range(0, 35) + 1020) % 1024;
      r    = $urandom();
      mode = $urandom_range(0, 4);
      txn(mode < 2 || mode == 4, mode >= 2, {r[31:10], lo[9:0]}, $urandom_range(0, 30), -1,
          $urandom_range(1, 3), 0, 16'($urandom()), 16'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
